wfg_drive_spi: RTL and testbench

- SPI serializer stage directly downstream of the waveform-generator core.
- Accepts one sample word per valid/ready handshake and shifts it out on sclk/cs/sdo, routed to the user I/O pads (sclk, cs, sdo on mprj_io[8], [9], [10]).
- Frame format is CPHA=0: cs low for the whole frame, data stable around the sampling (leading) edge, MSB first by default.
- Configuration comes from Wishbone-mapped registers held outside this block.

---
 rtl/wfg_drive_spi.sv | 210 +++++++++++++++++++++
 tb/tb_wfg_drive_spi.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wfg_drive_spi.sv
// SPI serializer for waveform-generator samples: one word per valid/ready
// handshake, shifted out CPHA=0 on sclk/cs/sdo with per-frame latched config.
module wfg_drive_spi #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_en_i,
  input  logic [DIV_W-1:0]  cfg_clkdiv_i,
  input  logic              cfg_cpol_i,
  input  logic              cfg_lsbfirst_i,
  input  logic [1:0]        cfg_width_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              spi_sclk_o,
  output logic              spi_cs_o,
  output logic              spi_sdo_o
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned NB_W  = 6;
  localparam int unsigned SA_W  = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    TRAIL = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]  tmr_q, tmr_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              lsb_q, lsb_d;
  logic [1:0]        width_q, width_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              sdo_q, sdo_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              tick;
  logic              last_bit;
  logic [NB_W-1:0]   n_bits;
  logic [SA_W-1:0]   sh_amt;
  logic [DATA_W-1:0] load_sh;
  logic              load_bit;

  assign accept   = (state_q == IDLE) && valid_i && ready_q;
  assign tick     = (tmr_q == div_q);
  assign last_bit = (bit_q == '0);

  // MSB-first frames are left-aligned so the outgoing bit is always the top bit.
  assign n_bits   = NB_W'({cfg_width_i, 3'b000}) + NB_W'(8);
  assign sh_amt   = SA_W'(DATA_W) - SA_W'(n_bits);
  assign load_sh  = cfg_lsbfirst_i ? data_i : (data_i << sh_amt);
  assign load_bit = cfg_lsbfirst_i ? data_i[0] : load_sh[DATA_W-1];

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LEAD;
      LEAD:    if (tick) state_d = TRAIL;
      TRAIL:   if (tick) state_d = last_bit ? HOLD : LEAD;
      HOLD:    if (tick) state_d = GAP;
      GAP:     if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    tmr_d   = tmr_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    lsb_d   = lsb_q;
    width_d = width_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    sdo_d   = sdo_q;
    ready_d = ready_q;
    busy_d  = busy_q;

    if (state_q != IDLE) begin
      tmr_d = tick ? '0 : tmr_q + DIV_W'(1);
    end

    case (state_q)
      IDLE: begin
        tmr_d   = '0;
        cs_d    = 1'b1;
        sclk_d  = cfg_cpol_i;
        sdo_d   = 1'b0;
        busy_d  = 1'b0;
        ready_d = cfg_en_i;
        if (accept) begin
          div_d   = cfg_clkdiv_i;
          cpol_d  = cfg_cpol_i;
          lsb_d   = cfg_lsbfirst_i;
          width_d = cfg_width_i;
          sh_d    = load_sh;
          sdo_d   = load_bit;
          bit_d   = CNT_W'(n_bits - NB_W'(1));
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      LEAD: begin
        if (tick) sclk_d = ~cpol_q;
      end
      TRAIL: begin
        if (tick) begin
          sclk_d = cpol_q;
          if (!last_bit) begin
            bit_d = bit_q - CNT_W'(1);
            if (lsb_q) begin
              sh_d  = sh_q >> 1;
              sdo_d = sh_q[1];
            end else begin
              sh_d  = sh_q << 1;
              sdo_d = sh_q[DATA_W-2];
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_d  = 1'b1;
          sdo_d = 1'b0;
        end
      end
      GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          ready_d = cfg_en_i;
          sclk_d  = cfg_cpol_i;
        end
      end
      default: begin
        cs_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmr_q   <= '0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      lsb_q   <= 1'b0;
      width_q <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      sdo_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      lsb_q   <= lsb_d;
      width_q <= width_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      sdo_q   <= sdo_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign spi_sclk_o = sclk_q;
  assign spi_cs_o   = cs_q;
  assign spi_sdo_o  = sdo_q;

  // Frame length is implied by the bit counter load; width is kept for observability.
  logic unused_width;
  assign unused_width = ^width_q;

endmodule

// File: tb/tb_wfg_drive_spi.sv
// Directed bench for wfg_drive_spi: a sclk-edge deserializer rebuilds each
// frame and measures cs-low length, sclk level lengths and accept spacing.
module tb_wfg_drive_spi;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [DIV_W-1:0]  div;
  logic              cpol;
  logic              lsb;
  logic [1:0]        width;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready, busy, sclk, cs, sdo;

  wfg_drive_spi #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .cfg_en_i      (en),
    .cfg_clkdiv_i  (div),
    .cfg_cpol_i    (cpol),
    .cfg_lsbfirst_i(lsb),
    .cfg_width_i   (width),
    .data_i        (data),
    .valid_i       (valid),
    .ready_o       (ready),
    .busy_o        (busy),
    .spi_sclk_o    (sclk),
    .spi_cs_o      (cs),
    .spi_sdo_o     (sdo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Deserializer: captures sdo on each leading sclk edge while cs is low
  logic        mon_cpol = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic [31:0] rx = '0;
  int          nbits = 0;
  int          cs_len = 0;
  int          run = 0;
  int          min_run = 0;
  int          max_run = 0;
  bit          edge_seen = 1'b0;
  logic [31:0] rx_q[$];
  int          len_q[$];
  int unsigned acc_q[$];

  always @(negedge clk) begin
    if (rst) begin
      rx = '0;
      nbits = 0;
      cs_len = 0;
      edge_seen = 1'b0;
      prev_cs = 1'b1;
      prev_sclk = sclk;
    end else begin
      if (valid && ready) acc_q.push_back(cyc);
      if (!cs) begin
        if (prev_cs) begin
          rx = '0; nbits = 0; cs_len = 0; edge_seen = 1'b0;
          run = 0; min_run = 1000; max_run = 0;
        end
        cs_len++;
        if (sclk != prev_sclk) begin
          if (edge_seen) begin
            if (run < min_run) min_run = run;
            if (run > max_run) max_run = run;
          end
          edge_seen = 1'b1;
          run = 0;
          if (sclk != mon_cpol) begin
            rx = {rx[30:0], sdo};
            nbits++;
          end
        end
        run++;
      end else if (!prev_cs) begin
        rx_q.push_back(rx);
        len_q.push_back(cs_len);
      end
      prev_cs = cs;
      prev_sclk = sclk;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic send(input logic [31:0] d);
    data = d;
    valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic wait_frames(input int k);
    int t = 0;
    while (rx_q.size() < k && t < 3000) begin
      @(posedge clk); t++;
    end
    #1;
    check("frame_count", 32'(rx_q.size()), 32'(k));
  endtask

  task automatic wait_bits(input int k);
    int t = 0;
    while (nbits < k && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    check("bit_progress", 32'(nbits >= k), 32'd1);
  endtask

  logic [31:0] stream [5] = '{32'd25094, 32'd46345, 32'd60543, 32'd65533, 32'd262134};

  initial begin
    #500000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst = 1'b1; en = 1'b0; div = '0; cpol = 1'b0; lsb = 1'b0;
    width = 2'd3; data = '0; valid = 1'b0;
    cycles(3);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; en = 1'b1;
    cycles(1);
    check("ready_after_rst", 32'(ready), 32'd1);

    // 32-bit MSB-first frame at H=1
    send(32'd25094);
    check("t1_busy", 32'(busy), 32'd1);
    k = 1;
    @(posedge clk); #1;
    while (!ready && k < 500) begin
      @(posedge clk); #1; k++;
    end
    check("t1_ready_latency", 32'(k), 32'd66);
    wait_frames(1);
    check("t1_data", rx_q.pop_front(), 32'd25094);
    check("t1_cs_len", 32'(len_q.pop_front()), 32'd65);

    // Back-to-back stream with valid held high
    acc_q.delete();
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = stream[i];
      wait_ready();
      @(posedge clk); #1;
    end
    valid = 1'b0;
    wait_frames(5);
    for (int i = 0; i < 5; i++) begin
      check("t2_data", rx_q.pop_front(), stream[i]);
      check("t2_cs_len", 32'(len_q.pop_front()), 32'd65);
    end
    check("t2_accepts", 32'(acc_q.size()), 32'd5);
    for (int i = 0; i + 1 < acc_q.size(); i++)
      check("t2_accept_spacing", acc_q[i+1] - acc_q[i], 32'd67);

    // 16-bit LSB-first frame at H=4
    width = 2'd1; div = 8'd3; lsb = 1'b1;
    send(32'h1234ABCD);
    wait_frames(1);
    check("t3_order", rx_q.pop_front(), 32'h0000B3D5);
    check("t3_cs_len", 32'(len_q.pop_front()), 32'd132);
    check("t3_nbits", 32'(nbits), 32'd16);
    check("t3_min_level", 32'(min_run), 32'd4);
    check("t3_max_level", 32'(max_run), 32'd4);

    // CPOL=1 byte at H=2, cpol flipped mid-frame
    width = 2'd0; div = 8'd1; lsb = 1'b0; cpol = 1'b1; mon_cpol = 1'b1;
    cycles(6);
    check("t4_sclk_idle", 32'(sclk), 32'd1);
    send(32'h000000A5);
    cycles(6);
    cpol = 1'b0;
    wait_frames(1);
    check("t4_data", rx_q.pop_front(), 32'h000000A5);
    check("t4_cs_len", 32'(len_q.pop_front()), 32'd34);
    check("t4_min_level", 32'(min_run), 32'd2);
    cycles(6);
    mon_cpol = 1'b0;

    // Reset mid-frame after 10 bits
    width = 2'd3; div = 8'd0;
    send(32'hCAFEF00D);
    wait_bits(10);
    rst = 1'b1;
    cycles(1);
    check("t5_cs", 32'(cs), 32'd1);
    check("t5_sclk", 32'(sclk), 32'd0);
    check("t5_sdo", 32'(sdo), 32'd0);
    check("t5_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    cycles(1);
    check("t5_ready_release", 32'(ready), 32'd1);
    width = 2'd0;
    send(32'd10);
    wait_frames(1);
    check("t5_data", rx_q.pop_front(), 32'd10);
    check("t5_cs_len", 32'(len_q.pop_front()), 32'd17);

    // Enable dropped mid-frame
    width = 2'd3;
    send(32'hDEADBEEF);
    wait_bits(5);
    en = 1'b0;
    wait_frames(1);
    check("t6_data", rx_q.pop_front(), 32'hDEADBEEF);
    check("t6_cs_len", 32'(len_q.pop_front()), 32'd65);
    cycles(4);
    check("t6_ready_off", 32'(ready), 32'd0);
    check("t6_busy_off", 32'(busy), 32'd0);
    en = 1'b1;
    cycles(1);
    check("t6_ready_on", 32'(ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
